// File: rtl/pe_tile_scheduler.sv
// pe_tile_scheduler: walks output channels and image tiles, fetching weights/inputs and issuing them to a PE.
// Optional busy/stall performance counters are enabled with SCHED_PERF_CNT_EN.
module pe_tile_scheduler #(
  parameter int PE_LAT = 3,
  parameter int STEP3  = 4,
  parameter int STEP1  = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] cfg_height,
  input  logic [8:0] cfg_width,
  input  logic [7:0] cfg_out_dim,
  input  logic       cfg_weight_size,
  output logic       busy,
  output logic       done,
  output logic       wt_req,
  input  logic       wt_ack,
  output logic [7:0] wt_dimen,
  output logic       in_req,
  input  logic       in_ack,
  output logic [8:0] in_low_h,
  output logic [8:0] in_high_h,
  output logic [8:0] in_low_w,
  output logic [8:0] in_high_w,
  output logic       pe_input_valid,
  output logic       pe_weight_valid,
  output logic       pe_weight_size,
  output logic [7:0] pe_weight_dimen,
  output logic       tile_done
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_stall
`endif
);
  typedef enum logic [2:0] {IDLE, WREQ, IREQ, ISSUE, DRAIN, DONE} state_t;
  localparam logic [3:0] LAST = 4'(PE_LAT - 1);
  state_t state_q, state_d;
  logic [8:0] h_q, h_d, w_q, w_d, row_q, row_d, col_q, col_d;
  logic [7:0] od_q, od_d, d_q, d_d;
  logic       ws_q, ws_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] stride, tail;
  logic       last_h, last_w, last_d;
  // Upper bound is clipped to the image edge; a zero dimension (reset/idle) reports 0.
  function automatic logic [8:0] hi(input logic [8:0] lo, input logic [8:0] dim);
    logic [9:0] a, b;
    a = {1'b0, lo} + 10'd5;
    b = {1'b0, dim} - 10'd1;
    return dim == '0 ? '0 : 9'(a < b ? a : b);
  endfunction
  assign stride = ws_q ? 10'(STEP3) : 10'(STEP1);
  assign tail = ws_q ? 10'd2 : 10'd0;
  assign last_h = {1'b0, row_q} + stride + tail >= {1'b0, h_q};
  assign last_w = {1'b0, col_q} + stride + tail >= {1'b0, w_q};
  assign last_d = d_q == od_q - 8'd1;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign wt_req = state_q == WREQ;
  assign in_req = state_q == IREQ;
  assign pe_input_valid = state_q == ISSUE;
  assign pe_weight_valid = state_q == ISSUE;
  assign tile_done = state_q == DRAIN && cnt_q == LAST;
  assign wt_dimen = d_q;
  assign pe_weight_dimen = d_q;
  assign pe_weight_size = ws_q;
  assign in_low_h = row_q;
  assign in_low_w = col_q;
  assign in_high_h = hi(row_q, h_q);
  assign in_high_w = hi(col_q, w_q);
  always_comb begin
    state_d = state_q;
    h_d = h_q;
    w_d = w_q;
    od_d = od_q;
    ws_d = ws_q;
    d_d = d_q;
    row_d = row_q;
    col_d = col_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        h_d = cfg_height;
        w_d = cfg_width;
        od_d = cfg_out_dim;
        ws_d = cfg_weight_size;
        d_d = '0;
        row_d = '0;
        col_d = '0;
        state_d = (cfg_height == '0 || cfg_width == '0 || cfg_out_dim == '0) ? DONE : WREQ;
      end
      WREQ: state_d = wt_ack ? IREQ : WREQ;
      IREQ: state_d = in_ack ? ISSUE : IREQ;
      ISSUE: begin
        cnt_d = '0;
        state_d = DRAIN;
      end
      DRAIN: if (cnt_q != LAST) cnt_d = cnt_q + 4'd1;
      else if (!last_w) begin
        col_d = col_q + stride[8:0];
        state_d = IREQ;
      end else if (!last_h) begin
        col_d = '0;
        row_d = row_q + stride[8:0];
        state_d = IREQ;
      end else begin
        col_d = '0;
        row_d = '0;
        d_d = last_d ? d_q : d_q + 8'd1;
        state_d = last_d ? DONE : WREQ;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      h_q <= '0;
      w_q <= '0;
      od_q <= '0;
      ws_q <= 1'b0;
      d_q <= '0;
      row_q <= '0;
      col_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      h_q <= h_d;
      w_q <= w_d;
      od_q <= od_d;
      ws_q <= ws_d;
      d_q <= d_d;
      row_q <= row_d;
      col_q <= col_d;
      cnt_q <= cnt_d;
    end
  end
`ifdef SCHED_PERF_CNT_EN
  logic [31:0] pc_q, pc_d, ps_q, ps_d;
  always_comb begin
    pc_d = pc_q;
    ps_d = ps_q;
    if (state_q == IDLE && start) begin
      pc_d = '0;
      ps_d = '0;
    end else begin
      if (busy && pc_q != '1) pc_d = pc_q + 32'd1;
      if (((state_q == WREQ && !wt_ack) || (state_q == IREQ && !in_ack)) && ps_q != '1) ps_d = ps_q + 32'd1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= '0;
      ps_q <= '0;
    end else begin
      pc_q <= pc_d;
      ps_q <= ps_d;
    end
  end
  assign perf_cycles = pc_q;
  assign perf_stall = ps_q;
`endif
endmodule

// File: tb/tb_pe_tile_scheduler.sv
// tb_pe_tile_scheduler: directed checks of the tile scheduler; a second instance runs with PE_LAT=1.
module tb_pe_tile_scheduler;
  logic clk = 0, reset = 1, start = 0;
  logic [8:0] cfg_height = 0, cfg_width = 0;
  logic [7:0] cfg_out_dim = 0;
  logic cfg_weight_size = 0, wt_ack = 0, in_ack = 0;
  logic busy, done, wt_req, in_req, pe_input_valid, pe_weight_valid, pe_weight_size, tile_done;
  logic [7:0] wt_dimen, pe_weight_dimen;
  logic [8:0] in_low_h, in_high_h, in_low_w, in_high_w;
  logic b_busy, b_done, b_wt_req, b_in_req, b_piv, b_pwv, b_pws, b_tile_done;
  logic [7:0] b_wt_dimen, b_pwd;
  logic [8:0] b_lh, b_hh, b_lw, b_hw;
`ifdef SCHED_PERF_CNT_EN
  logic [31:0] perf_cycles, perf_stall, b_perf_cycles, b_perf_stall;
`endif
  pe_tile_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .cfg_height(cfg_height), .cfg_width(cfg_width),
    .cfg_out_dim(cfg_out_dim), .cfg_weight_size(cfg_weight_size), .busy(busy), .done(done),
    .wt_req(wt_req), .wt_ack(wt_ack), .wt_dimen(wt_dimen), .in_req(in_req), .in_ack(in_ack),
    .in_low_h(in_low_h), .in_high_h(in_high_h), .in_low_w(in_low_w), .in_high_w(in_high_w),
    .pe_input_valid(pe_input_valid), .pe_weight_valid(pe_weight_valid),
    .pe_weight_size(pe_weight_size), .pe_weight_dimen(pe_weight_dimen), .tile_done(tile_done)
`ifdef SCHED_PERF_CNT_EN
    , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
  );
  pe_tile_scheduler #(.PE_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .cfg_height(cfg_height), .cfg_width(cfg_width),
    .cfg_out_dim(cfg_out_dim), .cfg_weight_size(cfg_weight_size), .busy(b_busy), .done(b_done),
    .wt_req(b_wt_req), .wt_ack(wt_ack), .wt_dimen(b_wt_dimen), .in_req(b_in_req), .in_ack(in_ack),
    .in_low_h(b_lh), .in_high_h(b_hh), .in_low_w(b_lw), .in_high_w(b_hw),
    .pe_input_valid(b_piv), .pe_weight_valid(b_pwv),
    .pe_weight_size(b_pws), .pe_weight_dimen(b_pwd), .tile_done(b_tile_done)
`ifdef SCHED_PERF_CNT_EN
    , .perf_cycles(b_perf_cycles), .perf_stall(b_perf_stall)
`endif
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clk) cyc++;
  logic [35:0] tiles[$];
  logic [7:0] wdims[$], pdims[$];
  int ntd, n_req, issue_cyc, lat, td_cyc, done_cyc, n_vmis;
  int b_ntd, b_wn, b_lat_bad, b_issue_cyc, b_td_cyc, b_done_cyc;
  always @(negedge clk) begin
    #1;
    if (wt_req && wt_ack) wdims.push_back(wt_dimen);
    if (wt_req || in_req) n_req++;
    if (pe_input_valid != pe_weight_valid) n_vmis++;
    if (pe_input_valid) begin
      tiles.push_back({in_low_h, in_high_h, in_low_w, in_high_w});
      pdims.push_back(pe_weight_dimen);
      issue_cyc = cyc;
    end
    if (tile_done) begin
      ntd++;
      lat = cyc - issue_cyc;
      td_cyc = cyc;
    end
    if (done) done_cyc = cyc;
    if (b_wt_req && wt_ack) b_wn++;
    if (b_piv) b_issue_cyc = cyc;
    if (b_tile_done) begin
      b_ntd++;
      if (cyc - b_issue_cyc != 1) b_lat_bad++;
      b_td_cyc = cyc;
    end
    if (b_done) b_done_cyc = cyc;
  end
  function automatic logic [35:0] tl(input int lh, input int hh, input int lw, input int hw);
    return {9'(lh), 9'(hh), 9'(lw), 9'(hw)};
  endfunction
  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic clr();
    tiles.delete(); wdims.delete(); pdims.delete();
    ntd = 0; n_req = 0; n_vmis = 0; lat = -1; td_cyc = -10; done_cyc = -20;
    b_ntd = 0; b_wn = 0; b_lat_bad = 0; b_td_cyc = -10; b_done_cyc = -20;
  endtask
  task automatic start_job(input int h, input int w, input int od, input int ws);
    int n = 0;
    while ((busy || b_busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    cfg_height = 9'(h); cfg_width = 9'(w); cfg_out_dim = 8'(od); cfg_weight_size = ws[0];
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_done(input bit which);
    int n = 0;
    while (!(which ? b_done : done) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done", 36'(n < 2000), 36'd1);
    #2;
  endtask
  logic [35:0] e21[4], e22[8];
  initial begin
    e21 = '{tl(0,5,0,5), tl(0,5,4,7), tl(4,7,0,5), tl(4,7,4,7)};
    e22 = '{tl(0,5,0,5), tl(0,5,6,11), tl(6,11,0,5), tl(6,11,6,11),
            tl(0,5,0,5), tl(0,5,6,11), tl(6,11,0,5), tl(6,11,6,11)};
    clr();
    repeat (2) @(negedge clk);
    chk("rst_ctl", {busy, done, wt_req, in_req, pe_input_valid, pe_weight_valid, pe_weight_size, tile_done}, 0);
    chk("rst_bounds", {in_low_h, in_high_h, in_low_w, in_high_w}, 0);
    chk("rst_dims", {wt_dimen, pe_weight_dimen}, 0);
    reset = 0; wt_ack = 1; in_ack = 1;
    @(negedge clk);
    // 8x8 3x3, one channel
    clr();
    start_job(8, 8, 1, 1);
    wait_done(0);
    chk("t21_ntiles", 36'(tiles.size()), 4);
    for (int i = 0; i < 4 && i < tiles.size(); i++) chk($sformatf("t21_tile%0d", i), tiles[i], e21[i]);
    chk("t21_tile_done", 36'(ntd), 4);
    chk("t21_lat", 36'(lat), 3);
    chk("t21_done_after", 36'(done_cyc), 36'(td_cyc + 1));
    chk("t21_wsize", 36'(pe_weight_size), 1);
    @(negedge clk);
    chk("t21_done_pulse", {busy, done}, 0);
    // 12x12 1x1, two channels
    clr();
    start_job(12, 12, 2, 0);
    wait_done(0);
    chk("t22_nwt", 36'(wdims.size()), 2);
    for (int i = 0; i < 2 && i < wdims.size(); i++) chk($sformatf("t22_wt%0d", i), 36'(wdims[i]), 36'(i));
    chk("t22_ntiles", 36'(tiles.size()), 8);
    for (int i = 0; i < 8 && i < tiles.size(); i++) begin
      chk($sformatf("t22_tile%0d", i), tiles[i], e22[i]);
      chk($sformatf("t22_pdim%0d", i), 36'(pdims[i]), 36'(i / 4));
    end
    chk("t22_tile_done", 36'(ntd), 8);
    chk("t22_strobes", 36'(n_vmis), 0);
    chk("t22_wsize", 36'(pe_weight_size), 0);
    // zero width
    clr();
    start_job(8, 0, 1, 1);
    chk("t23_busy_done", {busy, done}, 2'b11);
    @(negedge clk);
    chk("t23_idle", {busy, done}, 0);
    #2;
    chk("t23_no_req", 36'(n_req), 0);
    // input fetch stall
    clr();
    in_ack = 0;
    start_job(8, 8, 1, 1);
    chk("t24_wreq", {wt_req, in_req}, 2'b10);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t24_hold%0d", k), {in_req, in_low_h, in_high_h, in_low_w, in_high_w}, {1'b1, tl(0,5,0,5)});
      @(negedge clk);
    end
    in_ack = 1;
    @(negedge clk);
    chk("t24_issue", {in_req, pe_input_valid, pe_weight_valid}, 3'b011);
`ifdef SCHED_PERF_CNT_EN
    chk("t24_perf_stall", 36'(perf_stall), 5);
`endif
    wait_done(0);
    // reset mid-drain
    clr();
    start_job(8, 8, 1, 1);
    for (int n = 0; n < 100 && !pe_input_valid; n++) @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("t25_in_drain", {busy, pe_input_valid, tile_done}, 3'b100);
    #3 reset = 1;
    #1;
    chk("t25_rst_ctl", {busy, done, wt_req, in_req, pe_input_valid, pe_weight_valid, pe_weight_size, tile_done}, 0);
    chk("t25_rst_bounds", {in_low_h, in_high_h, in_low_w, in_high_w}, 0);
    chk("t25_rst_dims", {wt_dimen, pe_weight_dimen}, 0);
`ifdef SCHED_PERF_CNT_EN
    chk("t25_rst_perf", {perf_cycles, perf_stall}, 0);
`endif
    @(negedge clk);
    reset = 0;
    clr();
    start_job(8, 8, 1, 1);
    wait_done(0);
    chk("t25_replay_wt", 36'(wdims.size() > 0 ? wdims[0] : 8'hff), 0);
    chk("t25_replay_tile", tiles.size() > 0 ? tiles[0] : '1, tl(0,5,0,5));
    chk("t25_replay_n", 36'(ntd), 4);
    // PE_LAT=1 on 4x4 3x3, three channels
    clr();
    start_job(4, 4, 3, 1);
    wait_done(1);
    chk("t26_b_tiles", 36'(b_ntd), 3);
    chk("t26_b_wt", 36'(b_wn), 3);
    chk("t26_b_lat", 36'(b_lat_bad), 0);
    chk("t26_b_done_after", 36'(b_done_cyc), 36'(b_td_cyc + 1));
    wait_done(0);
    chk("t26_tiles", 36'(ntd), 3);
    chk("t26_tile0", tiles.size() > 0 ? tiles[0] : '1, tl(0,3,0,3));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
